// File: rtl/request_arbiter.sv
// Memory request arbiter: grants one of NREQ requesters onto a single memory port,
// holds the request until completion and masks the owner until it releases. Optional watchdog: REQ_TIMEOUT_EN.
module request_arbiter #(
  parameter int NREQ      = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [NREQ-1:0]    req_ren,
  input  logic [NREQ-1:0]    req_wen,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic [NREQ-1:0]    req_release,
  output logic [NREQ-1:0]    req_hit,
  output logic [DW-1:0]      req_rdata,
  output logic               req_err,
  output logic               mem_ren,
  output logic               mem_wen,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic               mem_wait,
  input  logic [DW-1:0]      mem_rdata
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d, grant_sel;
  logic [GW-1:0]   rr_q, rr_d, next_ptr;
  logic [NREQ-1:0] mask_q, mask_d, elig, hit_vec;
  logic [AW-1:0]   addr_q, sel_addr;
  logic [DW-1:0]   wdata_q, sel_wdata;
  logic            wr_q, sel_wr;
  logic            busy, done, abort, any_elig;
  logic [GW-1:0]   lo_sel, hi_sel;
  logic            hi_found;

  assign elig     = (req_ren | req_wen) & ~mask_q;
  assign any_elig = |elig;
  assign busy     = (state_q == BUSY);
  assign done     = busy & ~mem_wait;

  // Descending scan so the lowest qualifying index is the one left standing;
  // round-robin prefers indices at/after rr_q and falls back to the lowest overall.
  always_comb begin
    lo_sel   = '0;
    hi_sel   = '0;
    hi_found = 1'b0;
    for (int unsigned j = NREQ; j > 0; j--) begin
      if (elig[j-1]) begin
        lo_sel = GW'(j - 1);
        if (32'(rr_q) <= j - 1) begin
          hi_sel   = GW'(j - 1);
          hi_found = 1'b1;
        end
      end
    end
    grant_sel = (PRIO_MODE == 0 && hi_found) ? hi_sel : lo_sel;
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (32'(grant_sel) == j) begin
        sel_addr  = req_addr[j*AW +: AW];
        sel_wdata = req_wdata[j*DW +: DW];
        sel_wr    = req_wen[j];
      end
    end
  end

  always_comb begin
    hit_vec = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      hit_vec[j] = done && (32'(grant_q) == j);
    end
  end

  assign next_ptr = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

`ifdef REQ_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] wait_q;

  // Held at zero outside BUSY, so every transaction starts counting from zero.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wait_q <= '0;
    end else if (!busy) begin
      wait_q <= '0;
    end else if (mem_wait) begin
      wait_q <= wait_q + 1'b1;
    end
  end

  assign abort   = busy & mem_wait & (32'(wait_q) == TIMEOUT);
  assign req_err = abort;
`else
  assign abort   = 1'b0;
  // Without the watchdog TIMEOUT has no effect; this folds to a constant 0.
  assign req_err = (TIMEOUT < 0);
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    // Release is applied after the hit so a same-cycle release leaves the bit clear.
    mask_d  = (mask_q | hit_vec) & ~req_release;
    unique case (state_q)
      IDLE: begin
        if (any_elig) begin
          state_d = BUSY;
          grant_d = grant_sel;
        end
      end
      BUSY: begin
        if (done || abort) begin
          state_d = IDLE;
          if (PRIO_MODE == 0) begin
            rr_d = next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      mask_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      mask_q  <= mask_d;
      if (state_q == IDLE && any_elig) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        wr_q    <= sel_wr;
      end
    end
  end

  assign mem_ren   = busy & ~wr_q;
  assign mem_wen   = busy & wr_q;
  assign mem_addr  = busy ? addr_q : '0;
  assign mem_wdata = busy ? wdata_q : '0;
  assign req_hit   = hit_vec;
  assign req_rdata = (done && !wr_q) ? mem_rdata : '0;

endmodule

// File: doc/request_arbiter.md
Name: request_arbiter

Overview:
- Parametrised memory request unit; arbitrates NREQ requesters (e.g. fetch, load/store, coherence lanes) onto one memory port.
- Sits between the datapath/cache front-ends and the memory controller.
- Latches the granted request, holds it on the memory port until the memory completes, then returns a one-cycle hit to the owner.
- Keeps a per-channel mask so a completed request is not re-issued until its owner releases it.

Parameters:
NREQ, 2, number of requesters (>=1)
AW, 32, address width
DW, 32, data width
PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
TIMEOUT, 255, wait-cycle limit; used only with REQ_TIMEOUT_EN

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  synchronous active-low reset
req_ren  in  NREQ  per-channel read request
req_wen  in  NREQ  per-channel write request
req_addr  in  NREQ*AW  channel i at bits [i*AW +: AW]
req_wdata  in  NREQ*DW  channel i at bits [i*DW +: DW]
req_release  in  NREQ  clears channel mask (owner has consumed its hit)
req_hit  out  NREQ  one-cycle completion pulse, one-hot or zero
req_rdata  out  DW  read data, valid while req_hit is nonzero
req_err  out  1  timeout abort pulse
mem_ren  out  1  memory read strobe
mem_wen  out  1  memory write strobe
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_wait  in  1  high = memory not yet done
mem_rdata  in  DW  memory read data

Behaviour:
- Reset (nRST low at a CLK edge):
  - state=IDLE, rr_ptr=0, mask=0, latched regs=0.
  - All outputs 0.
  - Reset mid-transaction aborts it; no hit is issued.
- Eligible channel: (req_ren[i] | req_wen[i]) & ~mask[i].
- If ren and wen are both high, the request is a write.
- FSM IDLE:
  - mem_* = 0.
  - If any channel is eligible, select the grant:
    - PRIO_MODE=0: first eligible index at or after rr_ptr, wrapping modulo NREQ.
    - PRIO_MODE=1: lowest eligible index.
  - Latch grant index, addr, wdata and type; go to BUSY next edge.
- FSM BUSY:
  - mem_ren/mem_wen/mem_addr/mem_wdata driven from latched regs only; input changes are ignored.
  - When mem_wait=0:
    - req_hit[grant]=1 (combinational, same cycle).
    - req_rdata = mem_rdata for reads, 0 for writes.
    - mask[grant] is set.
    - PRIO_MODE=0: rr_ptr = (grant+1) mod NREQ.
    - Return to IDLE.
- Latency: request sampled in IDLE at cycle t → mem strobe at t+1 → earliest hit at t+1. Minimum 2 cycles per transaction; no back-to-back overlap.
- Owner deasserting its request while BUSY does not cancel the transaction; the hit is still delivered.
- Mask:
  - Set on hit.
  - Cleared on req_release[i].
  - Release and hit in the same cycle: release wins, mask stays 0.
- Grant pointer width: $clog2(NREQ), minimum 1 bit. NREQ=1 degenerates to a single masked channel.
- req_hit is never asserted in IDLE; at most one bit is set per cycle.

Optional Feature:
- Macro: REQ_TIMEOUT_EN.
- Defined:
  - A wait counter resets to 0 on entering BUSY and increments each BUSY cycle with mem_wait=1.
  - When the counter reaches TIMEOUT with mem_wait still 1, the block pulses req_err for one cycle, returns to IDLE with no hit and no mask set, and advances rr_ptr past the grant.
  - mem_wait falling in the same cycle the limit is hit counts as a normal completion.
- Undefined: no counter; BUSY waits indefinitely; req_err tied 0.

Test Plan:
1. NREQ=2, PRIO_MODE=0, both channels request reads (addr 0x100, 0x200), mem_wait=0 → ch0 hit at cycle 1 with mem_addr=0x100, then ch1 hit at cycle 3 with mem_addr=0x200. Each hit is one cycle; rr_ptr alternates.
2. Ch1 write 0xDEADBEEF to 0x40, mem_wait high 3 cycles → mem_wen, mem_addr=0x40, mem_wdata=0xDEADBEEF held stable 4 cycles; req_hit=2'b10 on the 4th cycle; req_rdata=0.
3. Ch0 keeps req_ren high after its hit, release low → ch0 not re-granted. Assert req_release[0] → ch0 re-granted on the next IDLE.
4. PRIO_MODE=1, ch0 and ch1 requesting continuously with release every hit → only ch0 served. Drop ch0 → ch1 served within 2 cycles.
5. nRST low during BUSY with mem_wait=1 → next cycle: all outputs 0, no req_hit, mask=0, state IDLE.
6. REQ_TIMEOUT_EN, TIMEOUT=4, mem_wait stuck 1 → req_err pulses once after 4 wait cycles; no req_hit; next channel is granted afterwards.
